// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC iteration controller and core.
// Angles use full-scale turn encoding: 2^32 corresponds to one full revolution.
package cordic_pkg;

    localparam int LUT_W     = 32;
    localparam int LUT_DEPTH = 20;
    localparam int CNT_W     = 5;

    localparam logic MODE_CIRC = 1'b1;
    localparam logic MODE_HYP  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } cordic_state_t;

    // round(atan(2^-i) * 2^32 / (2*pi))
    localparam logic [LUT_W-1:0] CIRC_LUT [LUT_DEPTH] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518
    };

    // round(atanh(2^-i) * 2^32 / (2*pi)); shift 0 is never used in hyperbolic mode
    localparam logic [LUT_W-1:0] HYP_LUT [LUT_DEPTH] = '{
        32'h00000000, 32'h1661788E, 32'h0A680D61, 32'h051EA6FC,
        32'h028CBFDD, 32'h01460E35, 32'h00A2FCE9, 32'h00517D2E,
        32'h0028BE6E, 32'h00145F32, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518
    };

    function automatic logic [LUT_W-1:0] lut_lookup(input logic mode,
                                                     input logic [CNT_W-1:0] idx);
        logic [LUT_W-1:0] word;
        word = '0;
        if (idx < CNT_W'(LUT_DEPTH)) begin
            word = (mode == MODE_CIRC) ? CIRC_LUT[idx] : HYP_LUT[idx];
        end
        return word;
    endfunction

    // Hyperbolic convergence needs shifts 4 and 13 executed twice.
    function automatic logic is_hyp_repeat(input logic [CNT_W-1:0] idx);
        return (idx == CNT_W'(4)) || (idx == CNT_W'(13));
    endfunction

endpackage

// File: rtl/cordic.sv
// Single combinational CORDIC micro-rotation (circular or hyperbolic).
// i_dprev = 1 rotates in the direction that decreases z by the LUT angle.
module cordic
    import cordic_pkg::*;
#(
    parameter int p_WIDTH   = 32,
    parameter int p_SHIFT_W = CNT_W
) (
    input  logic [p_WIDTH-1:0]   i_x,
    input  logic [p_WIDTH-1:0]   i_y,
    input  logic [p_WIDTH-1:0]   i_z,
    input  logic                 i_mode,
    input  logic [p_SHIFT_W-1:0] i_shift_amnt,
    input  logic [LUT_W-1:0]     i_lut,
    input  logic                 i_dprev,
    output logic [p_WIDTH-1:0]   o_x,
    output logic [p_WIDTH-1:0]   o_y,
    output logic [p_WIDTH-1:0]   o_z
);

    logic signed [p_WIDTH-1:0] x_sh;
    logic signed [p_WIDTH-1:0] y_sh;

    assign x_sh = $signed(i_x) >>> i_shift_amnt;
    assign y_sh = $signed(i_y) >>> i_shift_amnt;

    always_comb begin
        o_x = i_x;
        o_y = i_y;
        o_z = i_z;
        if (i_mode == MODE_CIRC) begin
            if (i_dprev) begin
                o_x = i_x - y_sh;
                o_y = i_y + x_sh;
                o_z = i_z - i_lut;
            end else begin
                o_x = i_x + y_sh;
                o_y = i_y - x_sh;
                o_z = i_z + i_lut;
            end
        end else begin
            // hyperbolic: x moves with y, not against it
            if (i_dprev) begin
                o_x = i_x + y_sh;
                o_y = i_y + x_sh;
                o_z = i_z - i_lut;
            end else begin
                o_x = i_x - y_sh;
                o_y = i_y - x_sh;
                o_z = i_z + i_lut;
            end
        end
    end

endmodule

// File: rtl/cordic_sequencer.sv
// Drives the single-step cordic core through the full iteration schedule for one
// job at a time, with valid/ready handshakes on both the job and result sides.
module cordic_sequencer
    import cordic_pkg::*;
#(
    parameter int p_WIDTH = 32,
    parameter int p_ITERS = 20
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [p_WIDTH-1:0] i_x,
    input  logic [p_WIDTH-1:0] i_y,
    input  logic [p_WIDTH-1:0] i_z,
    input  logic               i_mode,
    input  logic               i_vec,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [p_WIDTH-1:0] o_x,
    output logic [p_WIDTH-1:0] o_y,
    output logic [p_WIDTH-1:0] o_z,
    output logic               o_busy
);

    cordic_state_t      state_q;
    logic [p_WIDTH-1:0] x_q;
    logic [p_WIDTH-1:0] y_q;
    logic [p_WIDTH-1:0] z_q;
    logic               mode_q;
    logic               vec_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               rep_q;
    logic               rep_d;
    logic               last_iter;
    logic               ready_q;
    logic               valid_q;
    logic               busy_q;

    logic [p_WIDTH-1:0] core_x;
    logic [p_WIDTH-1:0] core_y;
    logic [p_WIDTH-1:0] core_z;
    logic [LUT_W-1:0]   lut_word;
    logic               dir;

    assign lut_word = lut_lookup(mode_q, cnt_q);
    assign dir      = vec_q ? y_q[p_WIDTH-1] : ~z_q[p_WIDTH-1];

    cordic #(
        .p_WIDTH   (p_WIDTH),
        .p_SHIFT_W (CNT_W)
    ) u_core (
        .i_x          (x_q),
        .i_y          (y_q),
        .i_z          (z_q),
        .i_mode       (mode_q),
        .i_shift_amnt (cnt_q),
        .i_lut        (lut_word),
        .i_dprev      (dir),
        .o_x          (core_x),
        .o_y          (core_y),
        .o_z          (core_z)
    );

    // A pending repeat holds the shift; the last shift only exits once its repeat is done.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        rep_d = 1'b0;
        if ((mode_q == MODE_HYP) && is_hyp_repeat(cnt_q) && !rep_q) begin
            cnt_d = cnt_q;
            rep_d = 1'b1;
        end
        last_iter = (cnt_q == CNT_W'(p_ITERS - 1)) && !rep_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mode_q  <= 1'b0;
            vec_q   <= 1'b0;
            cnt_q   <= '0;
            rep_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_valid && ready_q) begin
                        x_q     <= i_x;
                        y_q     <= i_y;
                        z_q     <= i_z;
                        mode_q  <= i_mode;
                        vec_q   <= i_vec;
                        cnt_q   <= (i_mode == MODE_CIRC) ? CNT_W'(0) : CNT_W'(1);
                        rep_q   <= 1'b0;
                        state_q <= ST_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    x_q   <= core_x;
                    y_q   <= core_y;
                    z_q   <= core_z;
                    rep_q <= rep_d;
                    if (last_iter) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_x     = x_q;
    assign o_y     = y_q;
    assign o_z     = z_q;

endmodule
